jtdd_mcu_com: RTL and testbench
===============================

// Module: jtdd_mcu_com
// PURPOSE
// - MCU-side counterpart of the main-CPU communication port: owns the shared RAM window decoded by com_cs,
//   and turns the main CPU's halt request and NMI strobe into MCU bus-halt and NMI signals.
// - Returns bus-available (mcu_ban) and the MCU-to-main interrupt (mcu_irqmain) to the main CPU.
// - Sits between jtdd_main and the HD63701 MCU core in the game top level.
// PARAMETERS
// - AW       9    shared RAM address width (2^AW bytes)
// - TIMEOUT  255  clk cycles to wait for mcu_ba before forcing a grant (only with JTDD_COM_TIMEOUT_EN)
// PORTS
// - clk          in   1   system clock
// - rst          in   1   reset, asynchronous, active-high
// - cen_main     in   1   main CPU clock enable (cpu_cen from jtdd_main)
// - cen_mcu      in   1   MCU clock enable
// - main_addr    in   AW  main CPU address (cpu_AB[AW-1:0])
// - main_dout    in   8   main CPU write data
// - main_rnw     in   1   main CPU read/not-write
// - com_cs       in   1   main CPU shared-RAM select
// - mcu_ram      out  8   shared RAM read data to main CPU
// - mcu_nmi_set  in   1   main CPU NMI request strobe (level for whole bus cycle)
// - mcu_halt     in   1   main CPU halt request level
// - mcu_ban      out  1   bus-available: 1 = MCU halted, main owns shared RAM
// - mcu_irqmain  out  1   interrupt request to main CPU
// - mcu_addr     in   AW  MCU shared RAM address
// - mcu_wdata    in   8   MCU write data
// - mcu_wr       in   1   MCU write enable (qualified by cen_mcu)
// - mcu_rdata    out  8   shared RAM read data to MCU
// - mcu_halt_n   out  1   halt pin to MCU, active-low
// - mcu_ba       in   1   MCU bus-available output
// - mcu_nmi      out  1   NMI to MCU, active-high level
// - mcu_nmi_ack  in   1   MCU clears NMI (port access pulse)
// - mcu_irq_trig in   1   MCU port bit raising main IRQ
// BEHAVIOUR
// - Reset: mcu_ban=0, mcu_halt_n=1, mcu_nmi=0, mcu_irqmain=0, mcu_ram=0, mcu_rdata=0, FSM=RUN.
//   RAM contents not reset.
// - RAM: true dual port, 2^AW x 8. Both read ports are registered: data appears 1 clk after the address.
//   Main write: com_cs & !main_rnw & cen_main & state==HALTED; otherwise dropped.
//   MCU write: mcu_wr & cen_mcu & state!=HALTED, so the two ports never write in the same cycle.
// - Halt FSM, all transitions on clk.
//   - RUN:    halt_n=1, ban=0. On cen_main & mcu_halt, go to REQ.
//   - REQ:    halt_n=0. On cen_mcu & mcu_ba, go to HALTED; mcu_ban=1 from the next clk.
//             If mcu_halt drops (sampled on cen_main), go to RUN.
//   - HALTED: halt_n=0, ban=1. On cen_main & !mcu_halt, go to REL; ban=0 and halt_n=1 on the same clk.
//   - REL:    On cen_mcu & !mcu_ba, go to RUN. mcu_halt re-asserted here is honoured only after RUN is reached.
// - rst mid-sequence: returns to RUN immediately; halt_n=1 and ban=0 asynchronously.
// - NMI: mcu_nmi is set on cen_main & mcu_nmi_set and cleared on mcu_nmi_ack.
//   Set and ack in the same clk: set wins. Repeated sets while pending are absorbed (single level).
// - IRQ to main: rising edge of mcu_irq_trig, sampled on cen_mcu, sets mcu_irqmain.
//   It stays high until the cen_main after the one following the set, guaranteeing one full main-CPU sample.
//   A new edge while high re-arms the hold.
// CONFIGURATION
// - JTDD_COM_TIMEOUT_EN defined: a counter runs in REQ. After TIMEOUT clk without mcu_ba, the FSM
//   forces HALTED (ban=1). The counter clears on leaving REQ.
// - JTDD_COM_TIMEOUT_EN undefined: REQ waits for mcu_ba indefinitely. No counter is synthesised.
// TESTING
// - Reset, then check outputs: mcu_ban=0, mcu_halt_n=1, mcu_nmi=0, mcu_irqmain=0.
// - Halt handshake: mcu_halt=1 -> halt_n=0. mcu_ba=1 -> mcu_ban=1 one clk after cen_mcu.
//   mcu_halt=0 -> ban=0 and halt_n=1. mcu_ba=0 -> FSM in RUN.
// - Shared RAM: MCU writes 8'h5A @9'h1F0. Halt granted, main reads 9'h1F0 -> mcu_ram=8'h5A.
//   Main writes 8'hC3 @9'h010 while not HALTED -> MCU readback of 9'h010 is unchanged.
// - NMI: mcu_nmi_set for one bus cycle -> mcu_nmi=1. Assert set and ack in the same clk -> mcu_nmi stays 1.
//   Ack alone -> mcu_nmi=0.
// - IRQ: mcu_irq_trig 0->1 -> mcu_irqmain=1 and held across at least one cen_main tick, then 0.
//   Holding trig high gives no second pulse.
// - Timeout (JTDD_COM_TIMEOUT_EN, TIMEOUT=16): mcu_halt=1 with mcu_ba=0 -> mcu_ban=1 after 16 clk in REQ.
//   Without the macro -> ban stays 0 for 1000 clk.

Source files
------------

// File: rtl/jtdd_mcu_com.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jtdd_mcu_com                                                      |
// | Purpose : MCU-side half of the main-CPU communication port. Holds the      |
// |           shared RAM window selected by com_cs. Converts the main CPU's    |
// |           halt request into an MCU halt / bus-available handshake, and     |
// |           its NMI strobe into an MCU NMI level. Raises an IRQ to the main  |
// |           CPU on a rising edge of an MCU port bit.                         |
// | Ports   : clk, rst (async, active-high), cen_main, cen_mcu                 |
// |           main side : main_addr, main_dout, main_rnw, com_cs, mcu_ram,     |
// |                       mcu_nmi_set, mcu_halt, mcu_ban, mcu_irqmain          |
// |           MCU side  : mcu_addr, mcu_wdata, mcu_wr, mcu_rdata, mcu_halt_n,  |
// |                       mcu_ba, mcu_nmi, mcu_nmi_ack, mcu_irq_trig           |
// | Config  : JTDD_COM_TIMEOUT_EN - when defined, REQ forces a grant after     |
// |           TIMEOUT clk cycles without mcu_ba.                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module jtdd_mcu_com #(
  parameter int AW      = 9,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_main,
  input  logic          cen_mcu,
  // main CPU side
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  input  logic          main_rnw,
  input  logic          com_cs,
  output logic [7:0]    mcu_ram,
  input  logic          mcu_nmi_set,
  input  logic          mcu_halt,
  output logic          mcu_ban,
  output logic          mcu_irqmain,
  // MCU side
  input  logic [AW-1:0] mcu_addr,
  input  logic [7:0]    mcu_wdata,
  input  logic          mcu_wr,
  output logic [7:0]    mcu_rdata,
  output logic          mcu_halt_n,
  input  logic          mcu_ba,
  output logic          mcu_nmi,
  input  logic          mcu_nmi_ack,
  input  logic          mcu_irq_trig
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2,
    ST_REL    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_ban;
  logic   w_halt_n;
  logic   w_timeout;

  // ---------------------------------------------------------------------------
  // Grant timeout (optional)
  // ---------------------------------------------------------------------------
`ifdef JTDD_COM_TIMEOUT_EN
  localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [c_CW-1:0] r_to_cnt;

  // Counts clk cycles spent in REQ; the grant is forced on the TIMEOUT-th one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_REQ && w_state_nxt == ST_REQ) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == ST_REQ) && (r_to_cnt == c_CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Halt handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ban       = 1'b0;
    w_halt_n    = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (cen_main && mcu_halt) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_halt_n = 1'b0;
        // A grant arriving together with a dropped request still completes;
        // the release then follows through HALTED/REL on the next cen_main.
        if ((cen_mcu && mcu_ba) || w_timeout) begin
          w_state_nxt = ST_HALTED;
        end else if (cen_main && !mcu_halt) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: begin
        w_halt_n = 1'b0;
        w_ban    = 1'b1;
        if (cen_main && !mcu_halt) w_state_nxt = ST_REL;
      end
      ST_REL: begin
        // A new halt request waits here until the MCU has dropped BA.
        if (cen_mcu && !mcu_ba) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Decoded from the state register, so rst clears them asynchronously.
  assign mcu_ban    = w_ban;
  assign mcu_halt_n = w_halt_n;

  // ---------------------------------------------------------------------------
  // Shared RAM
  // ---------------------------------------------------------------------------
  // Writes are mutually exclusive by FSM state, so a single write port with a
  // source mux is enough.
  logic [7:0]    r_mem [0:(1<<AW)-1];
  logic          w_main_we;
  logic          w_mcu_we;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;

  assign w_main_we = com_cs && !main_rnw && cen_main && (r_state == ST_HALTED);
  assign w_mcu_we  = mcu_wr && cen_mcu && (r_state != ST_HALTED);
  assign w_we      = w_main_we || w_mcu_we;
  assign w_waddr   = w_main_we ? main_addr : mcu_addr;
  assign w_wdata   = w_main_we ? main_dout : mcu_wdata;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcu_ram   <= 8'h00;
      mcu_rdata <= 8'h00;
    end else begin
      mcu_ram   <= r_mem[main_addr];
      mcu_rdata <= r_mem[mcu_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // NMI to MCU: set has priority over acknowledge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcu_nmi <= 1'b0;
    end else if (cen_main && mcu_nmi_set) begin
      mcu_nmi <= 1'b1;
    end else if (mcu_nmi_ack) begin
      mcu_nmi <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // IRQ to main CPU
  // ---------------------------------------------------------------------------
  // r_irq_hold marks that one cen_main has passed since the set; the request
  // drops on the following cen_main so the main CPU samples it at least once.
  logic r_trig_l;
  logic r_irq_hold;
  logic w_trig_edge;

  assign w_trig_edge = cen_mcu && mcu_irq_trig && !r_trig_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_l    <= 1'b0;
      r_irq_hold  <= 1'b0;
      mcu_irqmain <= 1'b0;
    end else begin
      if (cen_mcu) r_trig_l <= mcu_irq_trig;
      if (w_trig_edge) begin
        mcu_irqmain <= 1'b1;
        r_irq_hold  <= 1'b0;
      end else if (mcu_irqmain && cen_main) begin
        if (r_irq_hold) begin
          mcu_irqmain <= 1'b0;
          r_irq_hold  <= 1'b0;
        end else begin
          r_irq_hold  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtdd_mcu_com.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_jtdd_mcu_com                                                   |
// | Purpose : Directed self-checking bench for jtdd_mcu_com. Inputs change 1ns |
// |           after each rising edge; outputs are checked at that same point.  |
// |           Build with JTDD_COM_TIMEOUT_EN to exercise the grant timeout.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_jtdd_mcu_com;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen_main, cen_mcu;
  logic [AW-1:0] main_addr;
  logic [7:0]    main_dout;
  logic          main_rnw, com_cs;
  logic [7:0]    mcu_ram;
  logic          mcu_nmi_set, mcu_halt, mcu_ban, mcu_irqmain;
  logic [AW-1:0] mcu_addr;
  logic [7:0]    mcu_wdata;
  logic          mcu_wr;
  logic [7:0]    mcu_rdata;
  logic          mcu_halt_n, mcu_ba, mcu_nmi, mcu_nmi_ack, mcu_irq_trig;

  int checks = 0;
  int errors = 0;

  jtdd_mcu_com #(.AW(AW), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cen_main     (cen_main),
    .cen_mcu      (cen_mcu),
    .main_addr    (main_addr),
    .main_dout    (main_dout),
    .main_rnw     (main_rnw),
    .com_cs       (com_cs),
    .mcu_ram      (mcu_ram),
    .mcu_nmi_set  (mcu_nmi_set),
    .mcu_halt     (mcu_halt),
    .mcu_ban      (mcu_ban),
    .mcu_irqmain  (mcu_irqmain),
    .mcu_addr     (mcu_addr),
    .mcu_wdata    (mcu_wdata),
    .mcu_wr       (mcu_wr),
    .mcu_rdata    (mcu_rdata),
    .mcu_halt_n   (mcu_halt_n),
    .mcu_ba       (mcu_ba),
    .mcu_nmi      (mcu_nmi),
    .mcu_nmi_ack  (mcu_nmi_ack),
    .mcu_irq_trig (mcu_irq_trig)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    cen_main = 1'b1; cen_mcu = 1'b1;
    main_addr = '0; main_dout = 8'h00; main_rnw = 1'b1; com_cs = 1'b0;
    mcu_nmi_set = 1'b0; mcu_halt = 1'b0;
    mcu_addr = '0; mcu_wdata = 8'h00; mcu_wr = 1'b0;
    mcu_ba = 1'b0; mcu_nmi_ack = 1'b0; mcu_irq_trig = 1'b0;
    step(3);
    check("rst_ban",     32'(mcu_ban),     32'h0);
    check("rst_halt_n",  32'(mcu_halt_n),  32'h1);
    check("rst_nmi",     32'(mcu_nmi),     32'h0);
    check("rst_irqmain", 32'(mcu_irqmain), 32'h0);
    check("rst_ram",     32'(mcu_ram),     32'h0);
    check("rst_rdata",   32'(mcu_rdata),   32'h0);
    rst = 1'b0;
    step(1);

    // ---- shared RAM, MCU side owns it while running ----
    mcu_wr = 1'b1; mcu_addr = 9'h1F0; mcu_wdata = 8'h5A;
    step(1);
    mcu_addr = 9'h010; mcu_wdata = 8'h11;
    step(1);
    mcu_wr = 1'b0; mcu_addr = 9'h1F0;
    step(1);
    check("mcu_rd_1f0", 32'(mcu_rdata), 32'h5A);
    // main write while not halted must be dropped
    main_addr = 9'h010; main_dout = 8'hC3; main_rnw = 1'b0; com_cs = 1'b1;
    step(1);
    main_rnw = 1'b1; com_cs = 1'b0; mcu_addr = 9'h010;
    step(1);
    check("main_wr_dropped", 32'(mcu_rdata), 32'h11);

    // ---- halt handshake ----
    mcu_halt = 1'b1;
    step(1);
    check("req_halt_n", 32'(mcu_halt_n), 32'h0);
    check("req_ban",    32'(mcu_ban),    32'h0);
    cen_mcu = 1'b0; mcu_ba = 1'b1;
    step(1);
    check("ba_no_cen_ban", 32'(mcu_ban), 32'h0);
    cen_mcu = 1'b1;
    step(1);
    check("halted_ban",    32'(mcu_ban),    32'h1);
    check("halted_halt_n", 32'(mcu_halt_n), 32'h0);
    // main owns RAM: read, write, and MCU writes are dropped
    main_addr = 9'h1F0; com_cs = 1'b1;
    step(1);
    check("main_rd_1f0", 32'(mcu_ram), 32'h5A);
    main_addr = 9'h020; main_dout = 8'h77; main_rnw = 1'b0;
    mcu_addr = 9'h1F0; mcu_wdata = 8'hEE; mcu_wr = 1'b1;
    step(1);
    main_rnw = 1'b1; mcu_wr = 1'b0;
    step(1);
    check("main_rd_020", 32'(mcu_ram), 32'h77);
    main_addr = 9'h1F0;
    step(1);
    check("mcu_wr_dropped", 32'(mcu_ram), 32'h5A);
    com_cs = 1'b0;
    // release
    mcu_halt = 1'b0;
    step(1);
    check("rel_ban",    32'(mcu_ban),    32'h0);
    check("rel_halt_n", 32'(mcu_halt_n), 32'h1);
    mcu_halt = 1'b1;                     // ignored until RUN
    step(1);
    check("rel_ignores_halt", 32'(mcu_halt_n), 32'h1);
    mcu_ba = 1'b0;
    step(1);
    check("run_halt_n", 32'(mcu_halt_n), 32'h1);
    step(1);
    check("rearm_req_halt_n", 32'(mcu_halt_n), 32'h0);
    mcu_halt = 1'b0;                     // abandon request in REQ
    step(1);
    check("req_drop_halt_n", 32'(mcu_halt_n), 32'h1);
    check("req_drop_ban",    32'(mcu_ban),    32'h0);

    // ---- asynchronous reset mid-handshake ----
    mcu_halt = 1'b1; mcu_ba = 1'b1;
    step(2);
    check("pre_rst_ban", 32'(mcu_ban), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ban",    32'(mcu_ban),    32'h0);
    check("async_rst_halt_n", 32'(mcu_halt_n), 32'h1);
    step(1);
    mcu_halt = 1'b0; mcu_ba = 1'b0; rst = 1'b0;
    step(1);

    // ---- NMI ----
    mcu_nmi_set = 1'b1;
    step(1);
    mcu_nmi_set = 1'b0;
    check("nmi_set", 32'(mcu_nmi), 32'h1);
    mcu_nmi_set = 1'b1; mcu_nmi_ack = 1'b1;
    step(1);
    mcu_nmi_set = 1'b0; mcu_nmi_ack = 1'b0;
    check("nmi_set_wins", 32'(mcu_nmi), 32'h1);
    mcu_nmi_ack = 1'b1;
    step(1);
    mcu_nmi_ack = 1'b0;
    check("nmi_ack", 32'(mcu_nmi), 32'h0);
    cen_main = 1'b0; mcu_nmi_set = 1'b1;
    step(1);
    mcu_nmi_set = 1'b0;
    check("nmi_needs_cen", 32'(mcu_nmi), 32'h0);

    // ---- IRQ to main (cen_main pulsed by hand) ----
    mcu_irq_trig = 1'b1;
    step(1);
    check("irq_set", 32'(mcu_irqmain), 32'h1);
    step(3);
    check("irq_wait_cen", 32'(mcu_irqmain), 32'h1);
    cen_main = 1'b1;
    step(1);
    cen_main = 1'b0;
    check("irq_after_1st_cen", 32'(mcu_irqmain), 32'h1);
    cen_main = 1'b1;
    step(1);
    cen_main = 1'b0;
    check("irq_after_2nd_cen", 32'(mcu_irqmain), 32'h0);
    step(3);
    check("irq_no_repeat", 32'(mcu_irqmain), 32'h0);
    mcu_irq_trig = 1'b0;
    step(1);
    mcu_irq_trig = 1'b1;
    step(1);
    check("irq_set2", 32'(mcu_irqmain), 32'h1);
    cen_main = 1'b1;
    step(1);
    cen_main = 1'b0;
    mcu_irq_trig = 1'b0;
    step(1);
    mcu_irq_trig = 1'b1;                 // re-arm while high
    step(1);
    cen_main = 1'b1;
    step(1);
    cen_main = 1'b0;
    check("irq_rearm_hold", 32'(mcu_irqmain), 32'h1);
    cen_main = 1'b1;
    step(1);
    check("irq_rearm_clear", 32'(mcu_irqmain), 32'h0);
    mcu_irq_trig = 1'b0;

    // ---- grant timeout ----
    mcu_halt = 1'b1; mcu_ba = 1'b0;
    step(1);
    check("to_req_halt_n", 32'(mcu_halt_n), 32'h0);
`ifdef JTDD_COM_TIMEOUT_EN
    step(15);
    check("to_before_ban", 32'(mcu_ban), 32'h0);
    step(1);
    check("to_forced_ban", 32'(mcu_ban), 32'h1);
`else
    step(1000);
    check("no_to_ban",    32'(mcu_ban),    32'h0);
    check("no_to_halt_n", 32'(mcu_halt_n), 32'h0);
`endif
    mcu_halt = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
